// File: rtl/mutex_monitor_pkg.sv
// Shared types and limits for the mutex/stall monitor: FSM states, first-violation
// codes and legal parameter ranges.
package mutex_monitor_pkg;

    typedef enum logic [1:0] {
        ST_HOLDOFF = 2'd0,
        ST_ARMED   = 2'd1,
        ST_FAULT   = 2'd2
    } state_t;

    localparam logic [1:0] CODE_NONE  = 2'b00;
    localparam logic [1:0] CODE_MUTEX = 2'b01;
    localparam logic [1:0] CODE_STALL = 2'b10;
    localparam logic [1:0] CODE_BOTH  = 2'b11;

    localparam int N_CH_MIN     = 2;
    localparam int N_CH_MAX     = 32;
    localparam int HOLDOFF_MAX  = 255;
    localparam int MAX_HOLD_MIN = 1;
    localparam int MAX_HOLD_MAX = 65535;

    function automatic logic [1:0] viol_code(input logic mutex, input logic stall);
        if (mutex && stall)
            return CODE_BOTH;
        else if (stall)
            return CODE_STALL;
        else if (mutex)
            return CODE_MUTEX;
        else
            return CODE_NONE;
    endfunction

endpackage

// File: rtl/mutex_run_counter.sv
// Per-line run-length counter: counts consecutive high cycles, saturating at MAX_HOLD,
// and pulses stall on any further high cycle. Holds its value while frozen.
module mutex_run_counter #(
    parameter int MAX_HOLD = 16
) (
    input  logic clock,
    input  logic reset_n,
    input  logic line,
    input  logic freeze,
    output logic stall
);

    localparam int              RUN_W   = $clog2(MAX_HOLD + 1);
    localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(MAX_HOLD);

    logic [RUN_W-1:0] run_reg;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            run_reg <= '0;
        end else if (!freeze) begin
            if (!line)
                run_reg <= '0;
            else if (run_reg != RUN_MAX)
                run_reg <= run_reg + RUN_W'(1);
        end
    end

    // A high cycle arriving with the counter already full is the (MAX_HOLD+1)th one.
    assign stall = line && !freeze && (run_reg == RUN_MAX);

endmodule

// File: rtl/mutex_monitor.sv
// Mutual-exclusion and hold-time monitor for a set of one-hot channel lines.
// Define MUTEX_MONITOR_FATAL_EN to stop simulation on the first violating edge.
module mutex_monitor
    import mutex_monitor_pkg::*;
#(
    parameter int N_CH     = 3,
    parameter int HOLDOFF  = 4,
    parameter int MAX_HOLD = 16,
    parameter int CNT_W    = 8
) (
    input  logic            clock,
    input  logic            reset_n,
    input  logic [N_CH-1:0] ch_vld,
    input  logic            bypass,
    input  logic            clr,
    output logic            err_mutex,
    output logic            err_stall,
    output logic [CNT_W-1:0] err_cnt,
    output logic [N_CH-1:0] first_vec,
    output logic [1:0]      first_code,
    output logic            armed
);

    localparam logic [7:0] HOLD_LAST = 8'((HOLDOFF == 0) ? 0 : HOLDOFF - 1);
    localparam state_t     RST_STATE = (HOLDOFF == 0) ? ST_ARMED : ST_HOLDOFF;

    if (N_CH < N_CH_MIN || N_CH > N_CH_MAX || HOLDOFF < 0 || HOLDOFF > HOLDOFF_MAX ||
        MAX_HOLD < MAX_HOLD_MIN || MAX_HOLD > MAX_HOLD_MAX) begin : g_bad_params
        $error("mutex_monitor: parameter out of range");
    end

    state_t            state_reg;
    logic [7:0]        hold_cnt_reg;
    logic              err_mutex_reg;
    logic              err_stall_reg;
    logic [CNT_W-1:0]  err_cnt_reg;
    logic [N_CH-1:0]   first_vec_reg;
    logic [1:0]        first_code_reg;
    logic [N_CH-1:0]   stall_vec;

    for (genvar gi = 0; gi < N_CH; gi++) begin : g_run
        mutex_run_counter #(
            .MAX_HOLD (MAX_HOLD)
        ) u_run (
            .clock   (clock),
            .reset_n (reset_n),
            .line    (ch_vld[gi]),
            .freeze  (bypass),
            .stall   (stall_vec[gi])
        );
    end

    logic checking;
    logic multi_hot;
    logic mutex_hit;
    logic stall_hit;
    logic viol;

    // Clearing the lowest set bit leaves something only when two or more bits are set.
    assign multi_hot = (ch_vld & (ch_vld - N_CH'(1))) != '0;
    assign checking  = (state_reg != ST_HOLDOFF);
    assign mutex_hit = checking && !bypass && multi_hot;
    assign stall_hit = checking && !bypass && (|stall_vec);
    assign viol      = mutex_hit || stall_hit;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_reg      <= RST_STATE;
            hold_cnt_reg   <= '0;
            err_mutex_reg  <= 1'b0;
            err_stall_reg  <= 1'b0;
            err_cnt_reg    <= '0;
            first_vec_reg  <= '0;
            first_code_reg <= CODE_NONE;
        end else begin
            case (state_reg)
                ST_HOLDOFF: begin
                    if (hold_cnt_reg == HOLD_LAST)
                        state_reg <= ST_ARMED;
                    else
                        hold_cnt_reg <= hold_cnt_reg + 8'd1;
                end
                ST_ARMED: begin
                    if (viol && !clr) begin
                        state_reg      <= ST_FAULT;
                        first_vec_reg  <= ch_vld;
                        first_code_reg <= viol_code(mutex_hit, stall_hit);
                    end
                end
                ST_FAULT: begin
                    if (clr)
                        state_reg <= ST_ARMED;
                end
                default: state_reg <= RST_STATE;
            endcase

            // clr wins over a same-cycle violation, which is then simply dropped.
            if (clr) begin
                err_mutex_reg  <= 1'b0;
                err_stall_reg  <= 1'b0;
                err_cnt_reg    <= '0;
                first_vec_reg  <= '0;
                first_code_reg <= CODE_NONE;
            end else if (viol) begin
                err_mutex_reg <= err_mutex_reg | mutex_hit;
                err_stall_reg <= err_stall_reg | stall_hit;
                if (err_cnt_reg != '1)
                    err_cnt_reg <= err_cnt_reg + CNT_W'(1);
            end
        end
    end

    assign err_mutex  = err_mutex_reg;
    assign err_stall  = err_stall_reg;
    assign err_cnt    = err_cnt_reg;
    assign first_vec  = first_vec_reg;
    assign first_code = first_code_reg;
    assign armed      = (state_reg != ST_HOLDOFF);

`ifdef MUTEX_MONITOR_FATAL_EN
`ifndef SYNTHESIS
    always @(posedge clock) begin
        if (reset_n && viol && !clr) begin
            $display("mutex_monitor: %s violation, ch_vld=0x%0h",
                     (mutex_hit && stall_hit) ? "mutex+stall" :
                     (mutex_hit ? "mutex" : "stall"), ch_vld);
            $fatal(1, "mutex_monitor: stopping on violation");
        end
    end
`endif
`else
    // Violations are reported only through the flags and the counter.
`endif

endmodule

// File: tb/tb_mutex_monitor.sv
// Self-checking bench for mutex_monitor: directed scenarios plus random bursts,
// compared every cycle against a behavioural model.
module tb_mutex_monitor;

    localparam int N_CH     = 3;
    localparam int HOLDOFF  = 4;
    localparam int MAX_HOLD = 16;
    localparam int CNT_W    = 4;
    localparam int CNT_MAX  = (1 << CNT_W) - 1;

    logic             clock;
    logic             reset_n;
    logic [N_CH-1:0]  ch_vld;
    logic             bypass;
    logic             clr;
    logic             err_mutex;
    logic             err_stall;
    logic [CNT_W-1:0] err_cnt;
    logic [N_CH-1:0]  first_vec;
    logic [1:0]       first_code;
    logic             armed;

    int errors = 0;
    int checks = 0;

    mutex_monitor #(
        .N_CH     (N_CH),
        .HOLDOFF  (HOLDOFF),
        .MAX_HOLD (MAX_HOLD),
        .CNT_W    (CNT_W)
    ) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .ch_vld     (ch_vld),
        .bypass     (bypass),
        .clr        (clr),
        .err_mutex  (err_mutex),
        .err_stall  (err_stall),
        .err_cnt    (err_cnt),
        .first_vec  (first_vec),
        .first_code (first_code),
        .armed      (armed)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Behavioural model: cycle count since reset, unbounded run lengths, a fault bit.
    int        since_rst = 0;
    int        run [N_CH];
    bit        m_fault = 1'b0;
    bit        m_mutex = 1'b0;
    bit        m_stall = 1'b0;
    int        m_cnt   = 0;
    logic [N_CH-1:0] m_vec  = '0;
    logic [1:0]      m_code = 2'b00;

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            since_rst = 0;
            for (int i = 0; i < N_CH; i++) run[i] = 0;
            m_fault = 0; m_mutex = 0; m_stall = 0; m_cnt = 0; m_vec = '0; m_code = 2'b00;
        end else begin
            bit active, mv, sv;
            active = (since_rst >= HOLDOFF);
            mv = active && !bypass && ($countones(ch_vld) >= 2);
            sv = 0;
            for (int i = 0; i < N_CH; i++)
                if (active && !bypass && ch_vld[i] && run[i] >= MAX_HOLD) sv = 1;
            for (int i = 0; i < N_CH; i++)
                if (!bypass) run[i] = ch_vld[i] ? run[i] + 1 : 0;
            if (since_rst < HOLDOFF) since_rst++;
            if (clr) begin
                m_fault = 0; m_mutex = 0; m_stall = 0; m_cnt = 0; m_vec = '0; m_code = 2'b00;
            end else if (mv || sv) begin
                m_mutex = m_mutex || mv;
                m_stall = m_stall || sv;
                if (m_cnt < CNT_MAX) m_cnt++;
                if (!m_fault) begin
                    m_fault = 1;
                    m_vec   = ch_vld;
                    m_code  = {sv, mv};
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clock) begin
        chk("model.err_mutex",  32'(err_mutex),  32'(m_mutex));
        chk("model.err_stall",  32'(err_stall),  32'(m_stall));
        chk("model.err_cnt",    32'(err_cnt),    32'(m_cnt));
        chk("model.first_vec",  32'(first_vec),  32'(m_vec));
        chk("model.first_code", 32'(first_code), 32'(m_code));
        chk("model.armed",      32'(armed),      32'(since_rst >= HOLDOFF));
    end

    task automatic cyc(input logic [N_CH-1:0] v, input logic b, input logic c);
        ch_vld = v; bypass = b; clr = c;
        @(posedge clock); #1;
    endtask

    // Called 1 time unit after an edge; asserts reset between edges.
    task automatic do_reset();
        ch_vld = '0; bypass = 0; clr = 0;
        #3 reset_n = 1'b0;
        repeat (2) @(posedge clock);
        #1 reset_n = 1'b1;
    endtask

    initial begin
        reset_n = 1'b0; ch_vld = '0; bypass = 0; clr = 0;
        repeat (3) @(posedge clock);
        #1;
        chk("reset.err_cnt", 32'(err_cnt), 0);
        chk("reset.armed",   32'(armed),   0);
        chk("reset.flags",   32'({err_mutex, err_stall}), 0);
        reset_n = 1'b1;

        // Mutex inside holdoff is ignored; after arming it is flagged.
        repeat (3) cyc(3'b011, 0, 0);
        chk("holdoff.err_mutex", 32'(err_mutex), 0);
        chk("holdoff.armed",     32'(armed),     0);
        cyc(3'b000, 0, 0);
        chk("arm.armed", 32'(armed), 1);
        cyc(3'b000, 0, 0);
        cyc(3'b011, 0, 0);
        chk("mutex.err_mutex",  32'(err_mutex),  1);
        chk("mutex.first_vec",  32'(first_vec),  32'h3);
        chk("mutex.first_code", 32'(first_code), 32'h1);
        chk("mutex.err_cnt",    32'(err_cnt),    1);
        $display("txn mutex-after-holdoff cnt=%0d code=%0b", err_cnt, first_code);
        cyc(3'b000, 0, 1);
        chk("clr.err_cnt", 32'(err_cnt), 0);

        // Hold limit: 16 high cycles is legal, the 17th is a stall.
        repeat (16) cyc(3'b100, 0, 0);
        cyc(3'b000, 0, 0);
        chk("hold16.err_stall", 32'(err_stall), 0);
        repeat (16) cyc(3'b100, 0, 0);
        chk("hold17.before", 32'(err_stall), 0);
        cyc(3'b100, 0, 0);
        chk("hold17.err_stall",  32'(err_stall),  1);
        chk("hold17.first_code", 32'(first_code), 32'h2);
        chk("hold17.first_vec",  32'(first_vec),  32'h4);
        $display("txn stall-17 cnt=%0d code=%0b", err_cnt, first_code);
        cyc(3'b000, 0, 0);
        cyc(3'b000, 0, 1);

        // Bypass suppresses everything; counting resumes on the first open cycle.
        for (int k = 0; k < 20; k++) begin
            cyc(3'b111, 1, 0);
            chk("bypass.err_cnt", 32'(err_cnt), 0);
        end
        cyc(3'b111, 0, 0);
        chk("unbypass.err_cnt", 32'(err_cnt), 1);
        repeat (3) cyc(3'b111, 0, 0);
        chk("unbypass4.err_cnt", 32'(err_cnt), 4);
        $display("txn bypass cnt=%0d", err_cnt);
        cyc(3'b000, 0, 1);

        // Saturation, then clr beating a simultaneous violation.
        repeat (20) cyc(3'b011, 0, 0);
        chk("sat.err_cnt", 32'(err_cnt), 15);
        cyc(3'b011, 0, 0);
        chk("sat.hold", 32'(err_cnt), 15);
        cyc(3'b011, 0, 1);
        chk("clrwin.err_cnt",   32'(err_cnt),   0);
        chk("clrwin.err_mutex", 32'(err_mutex), 0);
        chk("clrwin.armed",     32'(armed),     1);
        $display("txn saturate-clr cnt=%0d", err_cnt);
        cyc(3'b000, 0, 0);

        // Both violation types in one cycle.
        repeat (16) cyc(3'b100, 0, 0);
        cyc(3'b101, 0, 0);
        chk("both.first_code", 32'(first_code), 32'h3);
        chk("both.err_cnt",    32'(err_cnt),    1);
        chk("both.first_vec",  32'(first_vec),  32'h5);
        $display("txn both cnt=%0d code=%0b", err_cnt, first_code);
        cyc(3'b000, 0, 1);

        // Asynchronous reset in the middle of a stall.
        repeat (20) cyc(3'b100, 0, 0);
        chk("prereset.err_stall", 32'(err_stall), 1);
        ch_vld = '0;
        #3 reset_n = 1'b0;
        #1;
        chk("async.outputs", 32'({err_mutex, err_stall, err_cnt, first_vec, first_code, armed}), 0);
        @(posedge clock);
        @(posedge clock);
        #1 reset_n = 1'b1;
        repeat (3) cyc(3'b000, 0, 0);
        chk("rearm.armed3", 32'(armed), 0);
        cyc(3'b000, 0, 0);
        chk("rearm.armed4", 32'(armed), 1);
        $display("txn async-reset armed=%0b", armed);

        // Random bursts checked by the per-cycle compare.
        for (int t = 0; t < 150; t++) begin
            logic [N_CH-1:0] v;
            int r, len;
            r = $urandom_range(0, 99);
            if (r < 55)      v = N_CH'(1) << $urandom_range(0, N_CH - 1);
            else if (r < 70) v = '0;
            else             v = N_CH'($urandom_range(0, 7));
            len = (r >= 90) ? $urandom_range(14, 22) : $urandom_range(1, 6);
            for (int k = 0; k < len; k++)
                cyc(v, $urandom_range(0, 9) == 0, $urandom_range(0, 29) == 0);
            $display("txn rand %0d vld=%03b len=%0d cnt=%0d", t, v, len, err_cnt);
            if ($urandom_range(0, 39) == 0) do_reset();
        end

        cyc(3'b000, 0, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
